// File: rtl/mc_ctr_unit.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes.
// Supports variable-latency memory (mem_ready), a wait timeout into FAULT, and SYSCALL halt/resume.
module mc_ctr_unit #(
    parameter int ALUOP_W = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               mem_ready,
    input  logic               resume,
    output logic               pcwrite,
    output logic               pcwritecond,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrca,
    output logic               bneorbeq,
    output logic               isjal,
    output logic               zeroextend,
    output logic               isshamt,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsource,
    output logic [ALUOP_W-1:0] aluop,
    output logic               instr_done,
    output logic               halted,
    output logic               fault,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(5);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_SYSC  = 6'b001100;

    state_t           cur, nxt;
    logic [5:0]       op_q, func_q;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_hit;

    assign state = cur;

    function automatic logic is_legal(input logic [5:0] o);
        case (o)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: is_legal = 1'b1;
            default:                          is_legal = 1'b0;
        endcase
    endfunction

    // Memory handshake: mem_ready=1 in FETCH or MEM completes the access that
    // cycle; while it is low, every strobe for the access is held unchanged.
    // The counter tracks consecutive not-ready cycles of the current access.
    assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT - 1));
    assign cnt_nxt     = ((cur == S_FETCH || cur == S_MEM) && !mem_ready) ? cnt + CNT_W'(1)
                                                                          : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= S_FETCH;
            cnt    <= '0;
            op_q   <= '0;
            func_q <= '0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
            if (cur == S_DECODE) begin
                op_q   <= op;
                func_q <= func;
            end
        end
    end

    always_comb begin
        nxt         = cur;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        bneorbeq    = 1'b0;
        isjal       = 1'b0;
        zeroextend  = 1'b0;
        isshamt     = 1'b0;
        alusrcb     = 2'b00;
        pcsource    = 2'b00;
        aluop       = ALU_ADD;
        instr_done  = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        case (cur)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    nxt     = S_DECODE;
                end else if (timeout_hit) begin
                    nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                if (op == OP_RTYPE && func == FN_SYSC) nxt = S_HALT;
                else if (!is_legal(op))                nxt = S_FAULT;
                else                                   nxt = S_EXEC;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                case (op_q)
                    OP_RTYPE: begin
                        aluop   = ALU_FUNC;
                        isshamt = (func_q == FN_SLL) || (func_q == FN_SRL);
                        if (func_q == FN_JR) begin
                            pcwrite    = 1'b1;
                            pcsource   = 2'b11;
                            instr_done = 1'b1;
                            nxt        = S_FETCH;
                        end else begin
                            nxt = S_WB;
                        end
                    end
                    OP_LW, OP_SW: begin
                        alusrcb = 2'b10;
                        nxt     = S_MEM;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
                        alusrcb    = 2'b10;
                        zeroextend = (op_q != OP_ADDI);
                        aluop      = (op_q == OP_ANDI) ? ALU_AND :
                                     (op_q == OP_ORI)  ? ALU_OR  :
                                     (op_q == OP_LUI)  ? ALU_LUI : ALU_ADD;
                        nxt        = S_WB;
                    end
                    OP_BEQ, OP_BNE: begin
                        aluop       = ALU_SUB;
                        pcwritecond = 1'b1;
                        pcsource    = 2'b01;
                        bneorbeq    = (op_q == OP_BNE);
                        instr_done  = 1'b1;
                        nxt         = S_FETCH;
                    end
                    OP_J, OP_JAL: begin
                        alusrca    = 1'b0;
                        pcwrite    = 1'b1;
                        pcsource   = 2'b10;
                        regwrite   = (op_q == OP_JAL);
                        isjal      = (op_q == OP_JAL);
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                    end
                    default: begin
                        alusrca = 1'b0;
                        nxt     = S_FAULT;
                    end
                endcase
            end
            S_MEM: begin
                iord     = 1'b1;
                memread  = (op_q == OP_LW);
                memwrite = (op_q == OP_SW);
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        nxt = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    nxt = S_FAULT;
                end
            end
            S_WB: begin
                regwrite   = 1'b1;
                regdst     = (op_q == OP_RTYPE);
                memtoreg   = (op_q == OP_LW);
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) nxt = S_FETCH;
            end
            S_FAULT: fault = 1'b1;
            default: nxt = S_FAULT;
        endcase
    end

endmodule
